// File: rtl/bus_arbiter.sv
// Purpose: round-robin owner selection for the shared register/data bus, driving mux select and bus enable.
// Latency: grant registered 1 cycle after request from IDLE/TURN; one dead TURN cycle between owners.
// Backpressure: level requests; an owner keeps the bus until it drops req or is force-released at MAX_HOLD.
//
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset
//   req    - per-requester level request
//   gnt    - one-hot registered grant
//   sel    - binary owner index to the bus mux selector (holds last owner while idle)
//   bus_en - high while an owner holds the bus (always equal to |gnt)
//   expire - single-cycle pulse on the dead cycle that follows a forced release
module bus_arbiter #(
  parameter int N_REQ          = 8,
  parameter int SELECTOR_WIDTH = 4,
  parameter int MAX_HOLD       = 4,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_REQ-1:0]          req,
  output logic [N_REQ-1:0]          gnt,
  output logic [SELECTOR_WIDTH-1:0] sel,
  output logic                      bus_en,
  output logic                      expire
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    TURN = 2'd2
  } state_t;

  // With no hold limit the counter simply parks at all-ones.
  localparam logic [CNT_WIDTH-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {CNT_WIDTH{1'b1}} : CNT_WIDTH'(MAX_HOLD);
  localparam logic [SELECTOR_WIDTH-1:0] LAST_IDX = SELECTOR_WIDTH'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  state_t                    state;
  logic [SELECTOR_WIDTH-1:0] ptr;
  logic [CNT_WIDTH-1:0]      hold_cnt;

  logic [N_REQ-1:0]          upper_mask;
  logic [N_REQ-1:0]          upper_req;
  logic [N_REQ-1:0]          pick_req;
  logic [SELECTOR_WIDTH-1:0] winner;
  logic [SELECTOR_WIDTH-1:0] ptr_after_owner;
  logic                      owner_req;
  logic                      rival_req;
  logic                      at_limit;
  logic                      forced;

  // Round-robin search: prefer the lowest set request at or above ptr; if none,
  // wrap around and take the lowest set request overall.
  always_comb begin
    upper_mask = ~((ONE << ptr) - ONE);
    upper_req  = req & upper_mask;
    pick_req   = (|upper_req) ? upper_req : req;
    winner     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (pick_req[i]) begin
        winner = SELECTOR_WIDTH'(i);
      end
    end
  end

  // gnt is the owner's one-hot while in OWN, so masking req with it avoids a
  // variable bit-select by sel.
  always_comb begin
    owner_req       = |(req & gnt);
    rival_req       = |(req & ~gnt);
    at_limit        = (MAX_HOLD != 0) && (hold_cnt == HOLD_SAT);
    forced          = owner_req && at_limit && rival_req;
    ptr_after_owner = (sel == LAST_IDX) ? '0 : sel + SELECTOR_WIDTH'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      hold_cnt <= '0;
      gnt      <= '0;
      sel      <= '0;
      bus_en   <= 1'b0;
      expire   <= 1'b0;
    end else begin
      expire <= 1'b0;
      case (state)
        IDLE, TURN: begin
          if (|req) begin
            state    <= OWN;
            gnt      <= ONE << winner;
            sel      <= winner;
            bus_en   <= 1'b1;
            hold_cnt <= CNT_WIDTH'(1);
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          if (!owner_req || forced) begin
            // Release: the following cycle is the dead turnaround cycle.
            // sel deliberately keeps the last owner.
            state  <= TURN;
            gnt    <= '0;
            bus_en <= 1'b0;
            ptr    <= ptr_after_owner;
            expire <= forced;
          end else if (hold_cnt != HOLD_SAT) begin
            hold_cnt <= hold_cnt + CNT_WIDTH'(1);
          end
        end
        default: begin
          state  <= IDLE;
          gnt    <= '0;
          bus_en <= 1'b0;
        end
      endcase
    end
  end

endmodule
